// File: rtl/alu_acc_seq.sv
// Accumulator ALU with carry/zero flags, valid/ready op handshake
// and a multi-cycle shift-add unsigned multiplier.
module alu_acc_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             op_valid,
    input  logic [3:0]       op_code,
    input  logic [WIDTH-1:0] r,
    output logic             op_ready,
    output logic             done,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] acc_hi,
    output logic             cy,
    output logic             z
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_ADC = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_SBB = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_LD  = 4'd8;
    localparam logic [3:0] OP_SHL = 4'd9;
    localparam logic [3:0] OP_SHR = 4'd10;
    localparam logic [3:0] OP_ROL = 4'd11;
    localparam logic [3:0] OP_ROR = 4'd12;
    localparam logic [3:0] OP_MUL = 4'd13;
    localparam logic [3:0] OP_CMP = 4'd14;
    localparam logic [3:0] OP_NOP = 4'd15;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_nxt;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     add_w;
    logic [WIDTH:0]     sub_w;
    logic               cin;
    logic               accept;
    logic               last_iter;
    logic [WIDTH-1:0]   alu_acc;
    logic               alu_cy;
    logic               alu_z;

    assign op_ready  = (state == S_IDLE);
    assign accept    = op_valid && op_ready;
    assign last_iter = (cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == S_IDLE) begin
            if (accept && op_code == OP_MUL) state_nxt = S_MUL;
        end else begin
            if (last_iter) state_nxt = S_IDLE;
        end
    end

    // Low half of prod starts as the multiplier and is shifted out
    // as the partial product grows in from the top.
    always_comb begin
        mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]}
                 + (prod[0] ? {1'b0, mcand} : '0);
        prod_nxt = {mul_sum, prod[WIDTH-1:1]};
    end

    always_comb begin
        cin     = (op_code == OP_ADC || op_code == OP_SBB) ? cy : 1'b0;
        add_w   = {1'b0, acc} + {1'b0, r} + {{WIDTH{1'b0}}, cin};
        sub_w   = {1'b0, acc} - {1'b0, r} - {{WIDTH{1'b0}}, cin};
        alu_acc = acc;
        alu_cy  = cy;
        unique case (op_code)
            OP_ADD, OP_ADC: begin
                alu_acc = add_w[WIDTH-1:0];
                alu_cy  = add_w[WIDTH];
            end
            OP_SUB, OP_SBB: begin
                alu_acc = sub_w[WIDTH-1:0];
                alu_cy  = sub_w[WIDTH];
            end
            OP_AND: begin alu_acc = acc & r; alu_cy = 1'b0; end
            OP_OR:  begin alu_acc = acc | r; alu_cy = 1'b0; end
            OP_XOR: begin alu_acc = acc ^ r; alu_cy = 1'b0; end
            OP_NOT: begin alu_acc = ~acc;    alu_cy = 1'b0; end
            OP_LD:  begin alu_acc = r;       alu_cy = 1'b0; end
            OP_SHL: begin
                alu_acc = {acc[WIDTH-2:0], 1'b0};
                alu_cy  = acc[WIDTH-1];
            end
            OP_SHR: begin
                alu_acc = {1'b0, acc[WIDTH-1:1]};
                alu_cy  = acc[0];
            end
            OP_ROL: begin
                alu_acc = {acc[WIDTH-2:0], cy};
                alu_cy  = acc[WIDTH-1];
            end
            OP_ROR: begin
                alu_acc = {cy, acc[WIDTH-1:1]};
                alu_cy  = acc[0];
            end
            OP_CMP: alu_cy = sub_w[WIDTH];
            OP_MUL, OP_NOP: ;
        endcase
        alu_z = (alu_acc == '0);
        if (op_code == OP_CMP) alu_z = (acc == r);
        if (op_code == OP_NOP) alu_z = z;
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            acc    <= '0;
            acc_hi <= '0;
            cy     <= 1'b0;
            z      <= 1'b1;
            done   <= 1'b0;
            cnt    <= '0;
            mcand  <= '0;
            prod   <= '0;
        end else begin
            done <= 1'b0;
            if (state == S_IDLE) begin
                if (accept && op_code == OP_MUL) begin
                    mcand <= acc;
                    prod  <= {{WIDTH{1'b0}}, r};
                    cnt   <= CW'(WIDTH);
                end else if (accept) begin
                    acc  <= alu_acc;
                    cy   <= alu_cy;
                    z    <= alu_z;
                    done <= 1'b1;
                end
            end else begin
                prod <= prod_nxt;
                cnt  <= cnt - CW'(1);
                if (last_iter) begin
                    acc    <= prod_nxt[WIDTH-1:0];
                    acc_hi <= prod_nxt[2*WIDTH-1:WIDTH];
                    cy     <= |prod_nxt[2*WIDTH-1:WIDTH];
                    z      <= ~|prod_nxt;
                    done   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/alu_acc_seq.md
Name: alu_acc_seq

Overview:
Parametrised accumulator ALU datapath that succeeds the fixed 8-bit ALU + accumulator + carry-register arrangement. The accumulator (acc), high-product register (acc_hi), carry flag (cy) and zero flag (z) are integrated into one block. A valid/ready operation handshake is added, along with carry-chained arithmetic, shifts and rotates, compare, and a multi-cycle shift-add unsigned multiply. It sits between the control unit/decoder and the register file operand bus.

Parameters:
WIDTH, 8, datapath width of acc, acc_hi and operand r; legal range WIDTH >= 2.

Ports:
clk  input  1  system clock; all state updates on the rising edge
Reset  input  1  synchronous, active-high reset
op_valid  input  1  operation request
op_code  input  4  operation select (see Behaviour)
r  input  WIDTH  second operand (register/immediate)
op_ready  output  1  block can accept an operation this cycle
done  output  1  one-cycle pulse: operation result committed
acc  output  WIDTH  accumulator
acc_hi  output  WIDTH  upper half of last MUL product
cy  output  1  carry/borrow flag
z  output  1  zero flag (result == 0)

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named clk and Reset.
- Reset (sampled on a rising edge): acc=0, acc_hi=0, cy=0, z=1, done=0, state=IDLE, op_ready=1. Reset overrides everything, including an in-flight MUL, which is aborted with no done pulse.
- Accept: an operation is accepted on an edge where op_valid && op_ready. op_valid while op_ready=0 is ignored; requests are not queued.
- op_ready = (state==IDLE), registered. No combinational path from op_valid to op_ready.
- Single-cycle ops:
  - Result, cy, z and done=1 are visible after the accept edge k.
  - done deasserts after edge k+1 unless a new operation is accepted on that edge.
  - Back-to-back acceptance every cycle is allowed.
- Op codes (WIDTH-bit arithmetic, wrap modulo 2^WIDTH):
  - 0 ADD: acc=A+R, cy=carry-out
  - 1 ADC: acc=A+R+cy, cy=carry-out
  - 2 SUB: acc=A-R, cy=borrow (1 iff A<R)
  - 3 SBB: acc=A-R-cy, cy=borrow
  - 4 AND, 5 OR, 6 XOR: bitwise with R, cy=0
  - 7 NOT: acc=~A, cy=0
  - 8 LD: acc=R, cy=0
  - 9 SHL: cy=A[MSB], acc=A<<1
  - 10 SHR: cy=A[0], acc=A>>1 (logical)
  - 11 ROL: {cy,acc}={A,cy} (rotate through carry)
  - 12 ROR: {acc,cy}={cy,A}
  - 13 MUL: multi-cycle, below
  - 14 CMP: acc unchanged, cy=borrow of A-R, z=(A==R)
  - 15 NOP: no state change except done pulse
- z: updated by every op except NOP. z = (new acc==0), except CMP as above.
- acc_hi: written only by MUL and by reset.
- MUL (unsigned A*R, 2*WIDTH-bit product), FSM IDLE -> MUL -> IDLE:
  - Accept edge k: latch multiplicand A and multiplier R, clear the partial product, counter=WIDTH, state=MUL, op_ready=0.
  - Each edge in MUL performs one shift-add iteration and decrements the counter.
  - Edge k+WIDTH (last iteration): acc=product[WIDTH-1:0], acc_hi=product[2W-1:W], cy=(acc_hi!=0), z=(full product==0), done=1, state=IDLE.
  - op_ready is low in cycles k+1..k+WIDTH and returns high after edge k+WIDTH.
  - acc, cy and z hold their pre-MUL values while busy.
- Counter width is clog2(WIDTH+1) bits. No other latency variation.

Test Plan:
1. WIDTH=8. Reset; LD 0x04; ADD 0x04; ADD 0x04 on consecutive cycles -> acc 0x04, 0x08, 0x0C; cy=0; z=0; done high for 3 consecutive cycles.
2. LD 0xF0; ADD 0x20 -> acc=0x10, cy=1. Then ADC 0x00 -> acc=0x11, cy=0. Then SUB 0x11 -> acc=0x00, z=1, cy=0.
3. LD 0x03; SUB 0x04 -> acc=0xFF, cy=1. Then SBB 0x00 -> acc=0xFE, cy=0. Then CMP 0xFE -> acc=0xFE, z=1, cy=0. Then CMP 0xFF -> cy=1, z=0.
4. LD 0x81 -> cy=0. ROL -> acc=0x02, cy=1. ROL -> acc=0x05, cy=0. SHR -> acc=0x02, cy=1. NOT -> acc=0xFD, cy=0.
5. LD 0xC8; MUL 0x0F -> op_ready low exactly 8 cycles; done 8 cycles after accept; acc=0xB8, acc_hi=0x0B, cy=1, z=0. An ADD 0x01 held on op_valid during busy is accepted on the first ready cycle, giving acc=0xB9.
6. LD 0x05; MUL 0x03; assert Reset on the 4th busy cycle -> acc=0, acc_hi=0, cy=0, z=1, op_ready=1 on the next cycle, no done pulse.
